// File: rtl/flush_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : flush_ctrl
//  Purpose  : Branch/jump flush controller at the execute stage. Decodes the
//             resolving opcode and the ALU compare flags to decide whether a
//             control transfer is taken. For a taken transfer it drives a
//             registered, multi-cycle, per-stage flush vector and a
//             one-cycle PC redirect pulse. A transfer that resolves while the
//             pipeline is stalled is deferred until the stall clears.
//  Ports    : clock, reset (sync, active-low)
//             ex_valid, opcode[OPW], isNotEqual, isLessThan, stall  (in)
//             flush[STAGES], redirect, busy, flush_count[16]         (out)
//  Params   : OPW (opcode width), STAGES (1..8), HOLD (1..15)
//  Options  : FLUSH_CTRL_STATS_EN - builds the saturating taken-transfer
//             counter; when undefined, flush_count is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module flush_ctrl #(
    parameter int OPW    = 5,
    parameter int STAGES = 2,
    parameter int HOLD   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [OPW-1:0]    opcode,
    input  logic              isNotEqual,
    input  logic              isLessThan,
    input  logic              stall,
    output logic [STAGES-1:0] flush,
    output logic              redirect,
    output logic              busy,
    output logic [15:0]       flush_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LD = 4'(HOLD);

    // ------------------------------------------------------------------
    // Opcode normalisation: only the low five bits carry the encoding,
    // and any set upper bit makes the opcode unrecognised.
    // ------------------------------------------------------------------
    logic [4:0] op5;
    logic       upper_zero;

    generate
        if (OPW > 5) begin : g_op_wide
            assign op5        = opcode[4:0];
            assign upper_zero = ~|opcode[OPW-1:5];
        end else if (OPW == 5) begin : g_op_exact
            assign op5        = opcode;
            assign upper_zero = 1'b1;
        end else begin : g_op_narrow
            assign op5        = {{(5-OPW){1'b0}}, opcode};
            assign upper_zero = 1'b1;
        end
    endgenerate

    logic taken_raw;
    logic req;

    always_comb begin
        taken_raw = 1'b0;
        case (op5)
            5'b00001, 5'b00011, 5'b00100: taken_raw = 1'b1;       // j, jal, jr
            5'b00010:                     taken_raw = isNotEqual; // bne
            5'b00110:                     taken_raw = isLessThan; // blt
            5'b10110:                     taken_raw = isNotEqual; // bex
            default:                      taken_raw = 1'b0;
        endcase
    end

    assign req = ex_valid & upper_zero & taken_raw;

    // ------------------------------------------------------------------
    // Control FSM. All outputs are computed as next-state values and
    // registered, so nothing reaches a port combinationally.
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    logic [STAGES-1:0] flush_q, flush_d;
    logic              redirect_q, redirect_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        flush_d    = '0;
        redirect_d = 1'b0;
        busy_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    busy_d = 1'b1;
                    if (stall) begin
                        state_d = ST_PENDING;
                    end else begin
                        state_d    = ST_FLUSH;
                        hold_d     = HOLD_LD;
                        flush_d    = '1;
                        redirect_d = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                // The deferred transfer is already committed; new inputs
                // are not looked at until it launches.
                busy_d = 1'b1;
                if (!stall) begin
                    state_d    = ST_FLUSH;
                    hold_d     = HOLD_LD;
                    flush_d    = '1;
                    redirect_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Requests seen here come from wrong-path instructions
                // that are themselves being squashed, so they are dropped.
                flush_d = '1;
                busy_d  = 1'b1;
                if (!stall) begin
                    if (hold_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        hold_d  = 4'd0;
                        flush_d = '0;
                        busy_d  = 1'b0;
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= 4'd0;
            flush_q    <= '0;
            redirect_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            busy_q     <= busy_d;
        end
    end

    assign flush    = flush_q;
    assign redirect = redirect_q;
    assign busy     = busy_q;

`ifdef FLUSH_CTRL_STATS_EN
    // Counts on the same edge that registers the redirect pulse, so the
    // count already includes a transfer in the cycle its redirect shows.
    logic [15:0] count_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= 16'h0000;
        end else if (redirect_d && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign flush_count = count_q;
`else
    assign flush_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/flush_ctrl.md
# flush_ctrl

Parametrised branch/jump flush controller for the pipelined processor. It sits at the execute stage and decodes the resolving instruction's opcode and the ALU compare flags (isNotEqual, isLessThan) to decide whether the control transfer is taken. It then drives a registered, multi-cycle, per-stage flush vector and a one-cycle PC redirect pulse. It adds stall-aware deferral, configurable flush depth and duration, and an optional flush counter.

## Interface
- OPW, 5: opcode width.
- STAGES, 2: number of younger pipeline stages squashed, one flush bit per stage. Legal range is 1..8.
- HOLD, 1: cycles the flush vector stays asserted per taken transfer. Legal range is 1..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- ex_valid  in  1  the execute stage holds a real (non-bubble) instruction.
- opcode  in  OPW  opcode of the instruction in execute.
- isNotEqual  in  1  ALU compare flag: operands differ.
- isLessThan  in  1  ALU compare flag: first operand is less than the second.
- stall  in  1  pipeline stall; no stage advances this cycle.
- flush  out  STAGES  per-stage squash; bit 0 is the youngest stage.
- redirect  out  1  one-cycle pulse that selects the branch target into the PC.
- busy  out  1  high while in PENDING or FLUSH.
- flush_count  out  16  number of taken transfers; see Configuration.

## Operation
Taken decode is combinational (low 5 opcode bits; upper bits must be zero):
- 00001 j, 00011 jal, 00100 jr: always taken.
- 00010 bne: taken when isNotEqual=1.
- 00110 blt: taken when isLessThan=1.
- 10110 bex: taken when isNotEqual=1.
- All other opcodes: not taken.

req = ex_valid & taken.

State machine:
- IDLE
  - req & !stall: go to FLUSH, load hold_cnt=HOLD, pulse redirect.
  - req & stall: go to PENDING.
- PENDING
  - Waits for stall=0; inputs are ignored.
  - On the first cycle with stall=0: go to FLUSH, load hold_cnt=HOLD, pulse redirect.
- FLUSH
  - flush = all ones, busy=1.
  - hold_cnt decrements only on cycles with stall=0.
  - When hold_cnt reaches 1 with stall=0, the next state is IDLE.
  - req during FLUSH is ignored, because that instruction is wrong-path and is itself being squashed.
- Back-to-back transfers: a req in the first cycle after returning to IDLE is accepted normally.
- ex_valid=0: the opcode and flags are don't-care.

Reset:
- When reset=0 at a clock edge, the next state is IDLE, flush=0, redirect=0, busy=0, hold_cnt=0, flush_count=0.
- Reset asserted mid-PENDING or mid-FLUSH discards the pending redirect.

## Timing
- All outputs are registered. None is combinational from the inputs.
- Latency: a req accepted at edge N gives redirect=1 and flush=all ones in cycle N+1.
- redirect is high for exactly one cycle per taken transfer, including deferred transfers.
- With no stall, flush is high for exactly HOLD cycles, starting in cycle N+1.
- Each stalled cycle extends the flush window by one.
- A stall while in PENDING delays redirect by one cycle per stalled cycle.
- busy rises in the same cycle flush rises, or PENDING is entered. It falls with the last flush cycle.
- A taken instruction that resolves on the same edge that the last FLUSH cycle ends is ignored (it is wrong-path). Acceptance resumes in the following cycle.

## Configuration
FLUSH_CTRL_STATS_EN:
- Defined: flush_count increments by 1 on every redirect pulse, saturating at 16'hFFFF. It is cleared by reset.
- Undefined: the counter logic is not built and flush_count is tied to 16'h0000. Control behaviour is otherwise identical.

## Test plan
- STAGES=2, HOLD=1, no stall. Opcode 00010, isNotEqual=1, ex_valid=1 at edge 5 -> redirect=1 and flush=2'b11 in cycle 6 only. Opcode 00010 with isNotEqual=0 -> flush stays 0.
- Sweep all 32 opcodes × 4 flag combinations with ex_valid=1 -> exactly j/jal/jr, bne(NE), blt(LT) and bex(NE) produce redirect. ex_valid=0 sweep -> never.
- STAGES=3, HOLD=3. Taken j with stall high for edges 10-12 -> PENDING, busy=1, flush=0. Stall falls at edge 13 -> redirect in cycle 14 and flush=3'b111 for cycles 14-16.
- HOLD=2. Stall pulse during FLUSH -> flush stays high 3 cycles. A taken bne presented mid-FLUSH -> no second redirect.
- Reset driven low during the second FLUSH cycle -> next cycle flush=0, busy=0, redirect=0. No redirect follows reset release.
- With FLUSH_CTRL_STATS_EN: 5 taken transfers -> flush_count=5. Preload near saturation, then 3 more transfers -> stays 16'hFFFF. Without the macro -> flush_count=0 throughout.
